mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Iterative HI/LO multiply/divide sequencer for MULT, MULTU, DIV, DIVU. Time-shares one
//  32-bit carry-lookahead adder (sum only, no carry out) across operand negation,
//  32 shift-add/subtract iterations and result sign fix-up. Sits beside the EX-stage ALU;
//  the pipeline stalls on busy and reads hi/lo.
// PARAMETERS
//  ITERS   32  iteration count; fixed by 32-bit operand width
// PORTS
//  clk     in   1   clock; all state changes on rising edge
//  rst     in   1   synchronous, active-high reset
//  start   in   1   request; sampled only in IDLE or DONE
//  op      in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with start
//  a       in   32  multiplicand / dividend (rs); captured with start
//  b       in   32  multiplier / divisor (rt); captured with start
//  busy    out  1   high PREP_A..FIX_H
//  done    out  1   one-cycle pulse in DONE; hi/lo valid from this cycle
//  dz      out  1   divide-by-zero flag of the last completed op; held until the next done
//  hi      out  32  product[63:32] / remainder; held between ops
//  lo      out  32  product[31:0] / quotient; held between ops
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, dz=0, hi=0, lo=0. rst mid-op aborts; no partial hi/lo write.
//  - States: IDLE -> PREP_A -> PREP_B -> ITER (x32) -> FIX_L -> FIX_H -> DONE -> IDLE,
//    or DONE -> PREP_A when start=1 in DONE (back-to-back).
//  - Accept edge N: start=1 in IDLE/DONE. busy=1 N+1..N+36. DONE/done=1 at N+37, with hi/lo
//    written on that edge. Latency fixed at 37 cycles for every op, including signs and b=0.
//  - start while busy: ignored, no queueing. op/a/b are don't-care except at accept.
//  - Adder use, one op per cycle: operand = neg ? ~x : x, other input 0, ci = neg.
//    Pass-through when neg=0 keeps latency constant.
//    PREP_A: |a| if signed op and a[31]. PREP_B: |b| if signed op and b[31].
//  - Carry out derived from MSBs: co = a31&b31 | (a31^b31)&~s31.
//  - Mult ITER: if lo[0], {hi,lo} <= {co,sum(hi,mcand),lo[31:1]}; else {hi,lo} >> 1.
//  - Div ITER (restoring): shift {rem,q} left 1; sum = rem + ~dvs + 1; take if
//    (shifted-out bit | co). Taken: rem <= sum, q[0] <= 1; else rem kept, q[0] <= 0.
//  - FIX_L/FIX_H, MULT: negate 64-bit product if a[31]^b[31]. FIX_L: lo <= ~lo+1.
//    FIX_H: hi <= ~hi + (lo==0), where lo is sampled before FIX_L.
//  - FIX_L/FIX_H, DIV: quotient negated if signs differ; remainder takes the dividend sign.
//  - MULT/MULTU: dz=0.
//  - b==0 on DIV/DIVU: dz=1, hi=a (original), lo=32'hFFFF_FFFF; iterations still run, same latency.
//  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no trap).
// CONFIGURATION
//  - MDU_DIV_EN defined: full behaviour above.
//  - MDU_DIV_EN undefined: divide datapath and dz logic removed; dz tied 0.
//    op[1]=1 is accepted and completes with the same 37-cycle latency, hi/lo <= 0.
// STRUCTURE
//  - Shared package mdu_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), state enum,
//    ITER_W=6, DIVZ_LO=32'hFFFF_FFFF.
//  - Sub-module: the existing cla32 adder, one instance. All muxing, the iteration counter
//    and the FSM stay in this module.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at N+37, hi=0xFFFFFFFE, lo=0x00000001.
//  2. MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0 b=-1 -> hi=lo=0.
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dz=0. DIVU a=100 b=7 -> lo=14, hi=2.
//  4. DIVU a=5 b=0 -> dz=1, hi=5, lo=0xFFFFFFFF, latency still 37.
//  5. start pulsed during busy, then start=1 in DONE -> mid-op pulse ignored; second op
//     done at DONE+37.
//  6. rst at ITER cycle 10 of a MULT -> next edge IDLE, busy=0, hi=lo=0, no done.
//     Repeat tests 3-4 with MDU_DIV_EN undefined -> hi=lo=0, dz=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, sequencer states and constants shared by the HI/LO multiply/divide unit.
package mdu_pkg;
    localparam int ITER_W = 6;
    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_PREP_A, S_PREP_B, S_ITER, S_FIX_L, S_FIX_H, S_DONE} state_e;
endpackage

// File: rtl/cla32.sv
// cla32: 32-bit carry-lookahead adder, sum only; 4-bit lookahead groups chained by group generate/propagate.
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] sum_o
);
    logic [30:0] g;
    logic [31:0] p, c;
    logic [7:0]  cg;
    logic [6:0]  gg, gp;
    assign g = a_i[30:0] & b_i[30:0];
    assign p = a_i ^ b_i;
    assign cg[0] = ci_i;
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int L = 4 * k;
        assign c[L]   = cg[k];
        assign c[L+1] = g[L] | p[L] & cg[k];
        assign c[L+2] = g[L+1] | p[L+1] & g[L] | p[L+1] & p[L] & cg[k];
        assign c[L+3] = g[L+2] | p[L+2] & g[L+1] | p[L+2] & p[L+1] & g[L] | p[L+2] & p[L+1] & p[L] & cg[k];
        if (k < 7) begin : g_la
            assign gp[k]   = &p[L+3:L];
            assign gg[k]   = g[L+3] | p[L+3] & g[L+2] | p[L+3] & p[L+2] & g[L+1] | p[L+3] & p[L+2] & p[L+1] & g[L];
            assign cg[k+1] = gg[k] | gp[k] & cg[k];
        end
    end
    assign sum_o = p ^ c;
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer sharing one cla32 adder; fixed 37-cycle latency.
// Divide datapath and dz only when MDU_DIV_EN is defined; otherwise divide ops complete with hi/lo = 0.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_e             state_q;
    logic [ITER_W-1:0]  cnt_q;
    logic [31:0]        wh_q, wl_q, x_q, hi_q, lo_q;
    logic               sa_q, sb_q, div_q, lz_q, busy_q, done_q;
    logic [31:0]        add_a, add_b, sum;
    logic               add_ci, co, take, is_div, neg, sgn;
`ifdef MDU_DIV_EN
    logic               dz_q, bz_q;
    logic [31:0]        a_q;
    assign is_div = div_q;
    assign dz     = dz_q;
`else
    assign is_div = 1'b0;
    assign dz     = 1'b0;
`endif
    assign sgn  = op == OP_MULT || op == OP_DIV;
    assign neg  = sa_q ^ sb_q;
    assign co   = add_a[31] & add_b[31] | (add_a[31] ^ add_b[31]) & ~sum[31];
    assign take = wh_q[31] | co;
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        case (state_q)
            S_PREP_A: begin
                add_a  = sa_q ? ~wl_q : wl_q;
                add_ci = sa_q;
            end
            S_PREP_B: begin
                add_a  = sb_q ? ~x_q : x_q;
                add_ci = sb_q;
            end
            S_ITER: begin
                add_a  = is_div ? {wh_q[30:0], wl_q[31]} : wh_q;
                add_b  = is_div ? ~x_q : x_q;
                add_ci = is_div;
            end
            S_FIX_L: begin
                add_a  = neg ? ~wl_q : wl_q;
                add_ci = neg;
            end
            S_FIX_H: begin
                add_a  = (is_div ? sa_q : neg) ? ~wh_q : wh_q;
                add_ci = is_div ? sa_q : neg & lz_q;
            end
            default: ;
        endcase
    end
    cla32 u_cla (
        .a_i   (add_a),
        .b_i   (add_b),
        .ci_i  (add_ci),
        .sum_o (sum)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= start ? S_PREP_A : S_IDLE;
                    busy_q  <= start;
                    if (start) begin
                        wl_q  <= a;
                        x_q   <= b;
                        sa_q  <= sgn & a[31];
                        sb_q  <= sgn & b[31];
                        div_q <= op[1];
`ifdef MDU_DIV_EN
                        bz_q  <= op[1] & (b == '0);
                        a_q   <= a;
`endif
                    end
                end
                S_PREP_A: begin
                    wl_q    <= sum;
                    state_q <= S_PREP_B;
                end
                S_PREP_B: begin
                    x_q     <= sum;
                    wh_q    <= '0;
                    cnt_q   <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    // divide: restoring step on {rem,q}; multiply: add-and-shift on {hi,lo}
                    if (is_div) begin
                        wh_q <= take ? sum : {wh_q[30:0], wl_q[31]};
                        wl_q <= {wl_q[30:0], take};
                    end else begin
                        {wh_q, wl_q} <= wl_q[0] ? {co, sum, wl_q[31:1]} : {1'b0, wh_q, wl_q[31:1]};
                    end
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= cnt_q == ITER_W'(ITERS - 1) ? S_FIX_L : S_ITER;
                end
                S_FIX_L: begin
                    wl_q    <= sum;
                    lz_q    <= wl_q == '0;
                    state_q <= S_FIX_H;
                end
                S_FIX_H: begin
`ifdef MDU_DIV_EN
                    hi_q <= bz_q ? a_q : sum;
                    lo_q <= bz_q ? DIVZ_LO : wl_q;
                    dz_q <= bz_q;
`else
                    hi_q <= div_q ? '0 : sum;
                    lo_q <= div_q ? '0 : wl_q;
`endif
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
